mant_align_pipe: RTL and testbench



---
 rtl/mant_align_pipe_pkg.sv | 29 ++
 rtl/mant_align_pipe_lane_shift_sticky.sv | 62 ++++++
 rtl/mant_align_pipe.sv | 156 +++++++++++++++
 tb/tb_mant_align_pipe.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mant_align_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mant_align_pipe_pkg
//   Shared GEMM datapath constants for the mantissa alignment pipe: the lane
//   count, the default per-lane exponent/mantissa/guard widths, and helper
//   functions that derive the magnitude width (A) and the signed lane width (W)
//   from the mantissa and guard widths.
//   No ports (package).
// -----------------------------------------------------------------------------
package mant_align_pipe_pkg;

   // Lanes in the GEMM datapath.
   localparam int LANES = 4;

   // Default per-lane field widths.
   localparam int EXP_WIDTH_DEF   = 4;
   localparam int MAN_WIDTH_DEF   = 3;
   localparam int GUARD_WIDTH_DEF = 3;

   // Magnitude width: hidden bit + stored mantissa + guard bits.
   function automatic int mag_width(input int man_w, input int guard_w);
      return 1 + man_w + guard_w;
   endfunction

   // Signed lane width: magnitude plus a sign bit for two's complement.
   function automatic int lane_width(input int man_w, input int guard_w);
      return mag_width(man_w, guard_w) + 1;
   endfunction

endpackage

// File: rtl/mant_align_pipe_lane_shift_sticky.sv
// -----------------------------------------------------------------------------
// lane_shift_sticky
//   Combinational per-lane alignment: restores the hidden bit, right-shifts the
//   magnitude by the exponent offset and folds every shifted-out bit into the
//   result LSB as a sticky bit.
//   Ports:
//     lane_exp_i  [EXP_W-1:0]  raw lane exponent (0 = zero/subnormal lane)
//     lane_man_i  [MAN_W-1:0]  stored mantissa, hidden bit excluded
//     shift_i     [EXP_W-1:0]  unsigned right-shift amount
//     mag_o       [MAG_W-1:0]  aligned magnitude with sticky merged in LSB
// -----------------------------------------------------------------------------
module lane_shift_sticky
   import mant_align_pipe_pkg::*;
#(
   parameter int EXP_W   = EXP_WIDTH_DEF,
   parameter int MAN_W   = MAN_WIDTH_DEF,
   parameter int GUARD_W = GUARD_WIDTH_DEF
) (
   input  logic [EXP_W-1:0]                       lane_exp_i,
   input  logic [MAN_W-1:0]                       lane_man_i,
   input  logic [EXP_W-1:0]                       shift_i,
   output logic [mag_width(MAN_W, GUARD_W)-1:0]   mag_o
);

   localparam int MAG_W = mag_width(MAN_W, GUARD_W);

   logic             hidden_s;
   logic             in_range_s;
   logic [EXP_W-1:0] shift_amt_s;
   logic [MAG_W-1:0] mag_in_s;
   logic [MAG_W-1:0] shifted_s;
   logic [MAG_W-1:0] lost_mask_s;
   logic             sticky_s;

   assign hidden_s   = |lane_exp_i;
   assign mag_in_s   = {hidden_s, lane_man_i, {GUARD_W{1'b0}}};
   assign in_range_s = (32'(shift_i) < 32'(MAG_W));

   // Out-of-range offsets are steered to a zero shift so the barrel shifter
   // only ever sees amounts below MAG_W; their result is chosen separately.
   assign shift_amt_s = in_range_s ? shift_i : {EXP_W{1'b0}};

   assign shifted_s   = mag_in_s >> shift_amt_s;
   // Ones in the positions that fall off the bottom of the shifter.
   assign lost_mask_s = ~({MAG_W{1'b1}} << shift_amt_s);
   assign sticky_s    = |(mag_in_s & lost_mask_s);

   // Select the lane result: zero lane, sticky-only, or shifted with sticky.
   always_comb begin
      mag_o = {MAG_W{1'b0}};
      if (!hidden_s) begin
         // Zero/subnormal lane: the offset is meaningless, contribute nothing.
         mag_o = {MAG_W{1'b0}};
      end else if (!in_range_s) begin
         // Everything shifted out; only the sticky survives.
         mag_o = {{(MAG_W-1){1'b0}}, 1'b1};
      end else begin
         mag_o = shifted_s | {{(MAG_W-1){1'b0}}, sticky_s};
      end
   end

endmodule

// File: rtl/mant_align_pipe.sv
// -----------------------------------------------------------------------------
// mant_align_pipe
//   Two-stage pipelined mantissa alignment for the 4-lane GEMM datapath.
//   S1 registers the aligned magnitudes, signs and max_exp; S2 registers the
//   two's-complement lanes, which are the block outputs. Valid/ready on both
//   sides with full throughput and back-pressure.
//   Ports:
//     clk, rst_n          clock; synchronous active-low reset
//     in_valid/in_ready   input handshake
//     in_sign  [3:0]      lane signs
//     in_exp   [4*E-1:0]  raw lane exponents
//     in_man   [4*M-1:0]  stored lane mantissas
//     exp_offset_num      per-lane right-shift amounts
//     max_exp  [E-1:0]    shared block exponent
//     out_valid/out_ready output handshake
//     aligned_man [4*W-1:0] signed aligned lanes, lane i at [W*i +: W]
//     out_max_exp [E-1:0] max_exp travelling with the beat
// -----------------------------------------------------------------------------
module mant_align_pipe
   import mant_align_pipe_pkg::*;
#(
   parameter int expWidth   = EXP_WIDTH_DEF,
   parameter int manWidth   = MAN_WIDTH_DEF,
   parameter int guardWidth = GUARD_WIDTH_DEF
) (
   input  logic                                            clk,
   input  logic                                            rst_n,
   input  logic                                            in_valid,
   output logic                                            in_ready,
   input  logic [LANES-1:0]                                in_sign,
   input  logic [LANES*expWidth-1:0]                       in_exp,
   input  logic [LANES*manWidth-1:0]                       in_man,
   input  logic [LANES*expWidth-1:0]                       exp_offset_num,
   input  logic [expWidth-1:0]                             max_exp,
   output logic                                            out_valid,
   input  logic                                            out_ready,
   output logic [LANES*lane_width(manWidth, guardWidth)-1:0] aligned_man,
   output logic [expWidth-1:0]                             out_max_exp
);

   localparam int MAG_W  = mag_width(manWidth, guardWidth);
   localparam int LANE_W = lane_width(manWidth, guardWidth);

   // Handshake enables.
   logic s1_en_s;
   logic s2_en_s;

   // Combinational lane results.
   logic [LANES*MAG_W-1:0]  shifted_mag_s;
   logic [LANES*LANE_W-1:0] signed_man_s;

   // Stage 1 state.
   logic                    s1_valid_q,   s1_valid_d;
   logic [LANES*MAG_W-1:0]  s1_mag_q,     s1_mag_d;
   logic [LANES-1:0]        s1_sign_q,    s1_sign_d;
   logic [expWidth-1:0]     s1_max_exp_q, s1_max_exp_d;

   // Stage 2 state (block outputs).
   logic                    s2_valid_q,   s2_valid_d;
   logic [LANES*LANE_W-1:0] s2_man_q,     s2_man_d;
   logic [expWidth-1:0]     s2_max_exp_q, s2_max_exp_d;

   // A stage may load when it is empty or its contents move on this cycle.
   assign s2_en_s  = !s2_valid_q | out_ready;
   assign s1_en_s  = !s1_valid_q | s2_en_s;
   assign in_ready = s1_en_s;

   // Per-lane shift/sticky and sign conversion.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [LANE_W-1:0] mag_ext_s;

      lane_shift_sticky #(
         .EXP_W   (expWidth),
         .MAN_W   (manWidth),
         .GUARD_W (guardWidth)
      ) u_shift (
         .lane_exp_i (in_exp[expWidth*i +: expWidth]),
         .lane_man_i (in_man[manWidth*i +: manWidth]),
         .shift_i    (exp_offset_num[expWidth*i +: expWidth]),
         .mag_o      (shifted_mag_s[MAG_W*i +: MAG_W])
      );

      assign mag_ext_s = {1'b0, s1_mag_q[MAG_W*i +: MAG_W]};

      // Negating a zero magnitude wraps back to zero, so -0 needs no special case.
      assign signed_man_s[LANE_W*i +: LANE_W] =
         s1_sign_q[i] ? (~mag_ext_s + {{(LANE_W-1){1'b0}}, 1'b1}) : mag_ext_s;
   end

   // Stage 1 next state: take a new beat when enabled, otherwise hold.
   always_comb begin
      s1_valid_d   = s1_valid_q;
      s1_mag_d     = s1_mag_q;
      s1_sign_d    = s1_sign_q;
      s1_max_exp_d = s1_max_exp_q;
      if (s1_en_s) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_mag_d     = shifted_mag_s;
            s1_sign_d    = in_sign;
            s1_max_exp_d = max_exp;
         end else begin
            s1_mag_d     = s1_mag_q;
            s1_sign_d    = s1_sign_q;
            s1_max_exp_d = s1_max_exp_q;
         end
      end else begin
         s1_valid_d = s1_valid_q;
      end
   end

   // Stage 2 next state: take the S1 beat when enabled, otherwise hold.
   always_comb begin
      s2_valid_d   = s2_valid_q;
      s2_man_d     = s2_man_q;
      s2_max_exp_d = s2_max_exp_q;
      if (s2_en_s) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_man_d     = signed_man_s;
            s2_max_exp_d = s1_max_exp_q;
         end else begin
            s2_man_d     = s2_man_q;
            s2_max_exp_d = s2_max_exp_q;
         end
      end else begin
         s2_valid_d = s2_valid_q;
      end
   end

   // Pipeline registers; reset discards any in-flight beats.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_mag_q     <= {(LANES*MAG_W){1'b0}};
         s1_sign_q    <= {LANES{1'b0}};
         s1_max_exp_q <= {expWidth{1'b0}};
         s2_valid_q   <= 1'b0;
         s2_man_q     <= {(LANES*LANE_W){1'b0}};
         s2_max_exp_q <= {expWidth{1'b0}};
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_mag_q     <= s1_mag_d;
         s1_sign_q    <= s1_sign_d;
         s1_max_exp_q <= s1_max_exp_d;
         s2_valid_q   <= s2_valid_d;
         s2_man_q     <= s2_man_d;
         s2_max_exp_q <= s2_max_exp_d;
      end
   end

   assign out_valid   = s2_valid_q;
   assign aligned_man = s2_man_q;
   assign out_max_exp = s2_max_exp_q;

endmodule

// File: tb/tb_mant_align_pipe.sv
// -----------------------------------------------------------------------------
// tb_mant_align_pipe
//   Self-checking bench for mant_align_pipe: directed lane values, streaming,
//   stall, mid-stream reset and a randomized phase, all scored against an
//   arithmetic reference of the alignment rules.
// -----------------------------------------------------------------------------
module tb_mant_align_pipe;

   localparam int EW = 4;
   localparam int MW = 3;
   localparam int GW = 3;
   localparam int L  = 4;
   localparam int A  = 1 + MW + GW;
   localparam int W  = A + 1;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [L-1:0]      in_sign;
   logic [L*EW-1:0]   in_exp;
   logic [L*MW-1:0]   in_man;
   logic [L*EW-1:0]   exp_offset_num;
   logic [EW-1:0]     max_exp;
   logic              out_valid;
   logic              out_ready;
   logic [L*W-1:0]    aligned_man;
   logic [EW-1:0]     out_max_exp;

   mant_align_pipe #(
      .expWidth   (EW),
      .manWidth   (MW),
      .guardWidth (GW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_sign        (in_sign),
      .in_exp         (in_exp),
      .in_man         (in_man),
      .exp_offset_num (exp_offset_num),
      .max_exp        (max_exp),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .aligned_man    (aligned_man),
      .out_max_exp    (out_max_exp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int acc_cnt = 0;
   int out_cnt = 0;

   logic [L*W+EW-1:0] exp_q[$];
   int                acc_q[$];
   logic              got_out   = 1'b0;
   logic [L*W-1:0]    last_out  = '0;
   logic              hold_pend = 1'b0;
   logic [L*W+EW-1:0] hold_val  = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
      n_tests++;
      if (obs !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, req);
      end
   endtask

   // Reference for one lane straight from the rules, in integer arithmetic.
   function automatic logic [W-1:0] ref_lane(input logic s, input int e, input int m, input int off);
      int mag;
      int r;
      if (e == 0) return '0;
      mag = ((1 << MW) + m) * (1 << GW);
      if (off >= A) begin
         r = 1;
      end else begin
         r = mag / (1 << off);
         if ((mag % (1 << off)) != 0) r = r | 1;
      end
      if (s) r = -r;
      return W'(r);
   endfunction

   function automatic logic [L*W-1:0] ref_beat();
      logic [L*W-1:0] b;
      b = '0;
      for (int i = 0; i < L; i++)
         b[W*i +: W] = ref_lane(in_sign[i], int'(in_exp[EW*i +: EW]),
                                int'(in_man[MW*i +: MW]), int'(exp_offset_num[EW*i +: EW]));
      return b;
   endfunction

   task automatic drive_idle();
      in_valid       = 1'b0;
      in_sign        = '0;
      in_exp         = '0;
      in_man         = '0;
      exp_offset_num = '0;
      max_exp        = '0;
   endtask

   task automatic rand_data();
      int e;
      in_sign = L'($urandom);
      for (int i = 0; i < L; i++) begin
         e = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15);
         in_exp[EW*i +: EW]         = EW'(e);
         in_man[MW*i +: MW]         = MW'($urandom);
         exp_offset_num[EW*i +: EW] = (e == 0) ? EW'(9) : EW'($urandom_range(0, 15));
      end
      max_exp = EW'($urandom);
   endtask

   // One clock: score handshakes at the falling edge, then step past the rising edge.
   task automatic cycle();
      logic [L*W+EW-1:0] e;
      logic              ov_req;
      @(negedge clk);
      cyc++;
      got_out = 1'b0;
      if (rst_n) begin
         if (hold_pend) check("hold_stable", {aligned_man, out_max_exp}, hold_val);
         check("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
         ov_req = 1'b0;
         if (exp_q.size() > 0) ov_req = (cyc - acc_q[0]) >= 2;
         check("out_valid", out_valid, ov_req);
         hold_pend = out_valid && !out_ready;
         hold_val  = {aligned_man, out_max_exp};
         if (out_valid && out_ready) begin
            got_out  = 1'b1;
            last_out = aligned_man;
            out_cnt++;
            if (exp_q.size() == 0) begin
               check("out_unexpected", out_valid, 1'b0);
            end else begin
               e = exp_q.pop_front();
               void'(acc_q.pop_front());
               check("beat", {aligned_man, out_max_exp}, e);
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back({ref_beat(), max_exp});
            acc_q.push_back(cyc);
            acc_cnt++;
         end
      end else begin
         hold_pend = 1'b0;
      end
      @(posedge clk);
      if (!rst_n) begin
         exp_q.delete();
         acc_q.delete();
      end
      #1;
   endtask

   task automatic reset_checks();
      check("rst_out_valid",   out_valid,   1'b0);
      check("rst_aligned_man", aligned_man, '0);
      check("rst_out_max_exp", out_max_exp, '0);
      check("rst_in_ready",    in_ready,    1'b1);
   endtask

   // Single beat on lane 0 (other lanes zero), checked against a fixed value.
   task automatic dir_test(input string tag, input logic s, input logic [EW-1:0] e,
                           input logic [MW-1:0] m, input logic [EW-1:0] off,
                           input logic [W-1:0] req);
      int waited;
      drive_idle();
      in_sign[0]             = s;
      in_exp[EW-1:0]         = e;
      in_man[MW-1:0]         = m;
      exp_offset_num[EW-1:0] = off;
      max_exp                = EW'(9);
      in_valid               = 1'b1;
      out_ready              = 1'b1;
      cycle();
      in_valid = 1'b0;
      waited   = 0;
      do begin
         cycle();
         waited++;
      end while (!got_out && waited < 8);
      check({tag, "_latency"}, waited, 2);
      check(tag, last_out[W-1:0], req);
   endtask

   initial begin
      int a0;
      int o0;
      drive_idle();
      out_ready = 1'b1;
      rst_n     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      reset_checks();

      dir_test("neg_off0",    1'b1, 4'd5, 3'b101, 4'd0,  8'h98);
      dir_test("pos_off2",    1'b0, 4'd5, 3'b101, 4'd2,  8'h1A);
      dir_test("pos_off4",    1'b0, 4'd5, 3'b101, 4'd4,  8'h07);
      dir_test("zero_lane",   1'b0, 4'd0, 3'b111, 4'd9,  8'h00);
      dir_test("sticky_only", 1'b0, 4'd6, 3'b010, 4'd12, 8'h01);
      dir_test("sticky_neg",  1'b1, 4'd6, 3'b010, 4'd12, 8'hFF);
      dir_test("off_eq_A",    1'b0, 4'd3, 3'b111, 4'd7,  8'h01);
      dir_test("off_A_m1",    1'b0, 4'd3, 3'b111, 4'd6,  8'h01);

      // Back-to-back stream with the consumer always ready.
      o0 = out_cnt;
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         rand_data();
         in_valid = 1'b1;
         cycle();
      end
      drive_idle();
      repeat (3) cycle();
      check("stream_count", out_cnt - o0, 8);

      // Stall with the consumer blocked: only two beats fit.
      a0 = acc_cnt;
      o0 = out_cnt;
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         rand_data();
         in_valid = 1'b1;
         cycle();
      end
      check("stall_accepted", acc_cnt - a0, 2);
      drive_idle();
      out_ready = 1'b1;
      repeat (4) cycle();
      check("stall_drained", out_cnt - o0, 2);

      // Reset with two beats in flight.
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         rand_data();
         in_valid = 1'b1;
         cycle();
      end
      drive_idle();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      reset_checks();
      dir_test("post_reset", 1'b0, 4'd5, 3'b101, 4'd2, 8'h1A);

      // Randomized traffic with random back-pressure.
      for (int k = 0; k < 400; k++) begin
         rand_data();
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      drive_idle();
      out_ready = 1'b1;
      repeat (4) cycle();
      check("final_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
